neuron_layer_seq: RTL and testbench
===================================

// Module: neuron_layer_seq
// PURPOSE
//  Time-multiplexed, parametrised fully-connected layer: N_IN signed fixed-point activations in,
//  N_OUT activations out, via one shared MAC. Weights/biases are register-file programmable.
//  Successor to the fixed 2-in/9-out combinational output layer; valid/ready on both sides.
// PARAMETERS
//  DATA_W  20  activation/weight/bias width, two's complement
//  FRAC_W  12  fractional bits (Q8.12 at default)
//  N_IN    2   inputs per neuron
//  N_OUT   9   neurons (outputs)
//  ACC_W   2*DATA_W+$clog2(N_IN)+1  accumulator width (derived localparam, not overridable)
// PORTS
//  clk        in   1               clock, rising edge
//  rst_n      in   1               asynchronous active-low reset
//  in_valid   in   1               input vector valid
//  in_ready   out  1               layer idle, can accept a vector
//  in_data    in   N_IN*DATA_W     packed activations, element i at [i*DATA_W +: DATA_W]
//  out_valid  out  1               result vector valid
//  out_ready  in   1               consumer accepts results
//  out_data   out  N_OUT*DATA_W    packed results, neuron o at [o*DATA_W +: DATA_W]
//  cfg_we     in   1               weight/bias write strobe
//  cfg_addr   in   $clog2(N_OUT*(N_IN+1))  0..N_OUT*N_IN-1: w[o*N_IN+i]; then bias[o]
//  cfg_wdata  in   DATA_W          write data
//  cfg_ready  out  1               =1 in IDLE only; writes with cfg_ready=0 are dropped
// BEHAVIOUR
//  - Reset: in_ready=1, out_valid=0, out_data=0, cfg_ready=1, all weights/biases=0, FSM=IDLE.
//  - FSM IDLE -> MAC on in_valid&in_ready (in_data captured); MAC -> BIAS after N_IN cycles;
//    BIAS -> MAC (next neuron) or DONE after neuron N_OUT-1; DONE -> IDLE on out_ready.
//  - MAC: acc += in[i]*w[o*N_IN+i], one product per cycle, i=0..N_IN-1; acc cleared at neuron start.
//  - BIAS: acc + (bias[o] <<< FRAC_W) + (1<<(FRAC_W-1)), >>> FRAC_W (round half up),
//    saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1], write to out_data slot o.
//  - Latency accept->out_valid: N_OUT*(N_IN+1)+1 cycles (28 at defaults). in_ready=0 until DONE handshake.
//  - out_valid held, out_data stable while out_ready=0; in_ready=1 cycle after out handshake.
//  - cfg write in IDLE takes effect for next accepted vector; cfg_we with in_valid same cycle: both taken.
//  - out-of-range cfg_addr ignored. Reset mid-compute aborts: no out_valid, state as reset.
// CONFIGURATION
//  NEURON_RELU_EN defined: after saturation, negative results forced to 0 (ReLU).
//  Not defined: linear output (saturated value passed through). No other behaviour differs.
// STRUCTURE
//  Package neuron_pkg: default DATA_W/FRAC_W, fixed-point ONE constant, FSM state enum
//   (IDLE, MAC, BIAS, DONE), saturate/round function.
//  Sub-module neuron_mac: signed multiply-accumulate with clear, enable, rounding+saturation output.
//  Top: FSM, input/output registers, weight/bias register file, index counters.
// TESTING (defaults, Q8.12)
//  1 all w=0x01000, b=0; in={0x05AF4,0xFED26} -> every out=0x0481A, out_valid at cycle 28.
//  2 w=0x7FFFF, in=0x7FFFF x2 -> out=0x7FFFF; negate inputs -> 0x80000 (0x00000 with NEURON_RELU_EN).
//  3 rounding: w[0]=0x00800, w[1]=0, in0=0x00001 -> 0x00001; in0=0xFFFFF -> 0x00000.
//  4 bias only: w=0, b[o]=o*0x01000 -> out[o]=o*0x01000; cfg_we while busy -> dropped, result unchanged.
//  5 backpressure: out_ready=0 for 5 cycles -> out_valid/out_data stable, in_ready=0; new vector taken after.
//  6 rst_n low at cycle 4 of compute -> out_valid=0, in_ready=1, weights 0; next vector gives bias-only 0s.

Source files
------------

// File: rtl/neuron_pkg.sv
// neuron_pkg
// Shared definitions for the time-multiplexed neuron layer:
//   - default fixed-point format (Q8.12, 20-bit two's complement)
//   - FSM state encoding
//   - round-half-up / saturate helper used by the MAC output stage
// Optional feature macro used by the files importing this package: NEURON_RELU_EN.
package neuron_pkg;

    localparam int DATA_W_DEF = 20;
    localparam int FRAC_W_DEF = 12;

    // 1.0 in the default Q8.12 format
    localparam logic [DATA_W_DEF-1:0] ONE = 20'h01000;

    // Helper arithmetic runs at a fixed 64-bit width; the accumulator plus the
    // shifted bias must fit in this, which holds up to DATA_W of about 30.
    localparam int CALC_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_BIAS = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Round half up at bit frac_w, then clamp to a data_w-bit signed range.
    function automatic logic signed [CALC_W-1:0] round_sat(
        input logic signed [CALC_W-1:0] val,
        input int                       frac_w,
        input int                       data_w
    );
        logic signed [CALC_W-1:0] r;
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        r  = (val + (64'sd1 <<< (frac_w - 1))) >>> frac_w;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (r > hi)
            r = hi;
        else if (r < lo)
            r = lo;
        return r;
    endfunction

endpackage

// File: rtl/neuron_mac.sv
// neuron_mac
// Signed multiply-accumulate with synchronous clear and enable, plus a
// combinational output stage: acc + (bias <<< FRAC_W), rounded half up,
// shifted down by FRAC_W and saturated to DATA_W bits.
// Macro: NEURON_RELU_EN defined -> negative saturated results forced to 0.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   clr          zero the accumulator (priority over en)
//   en           acc += a*b
//   a, b         signed operands
//   bias         signed bias for the output stage
//   result       rounded, saturated (optionally rectified) output
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int ACC_W  = 2*DATA_W_DEF + 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic signed [DATA_W-1:0] bias,
    output logic signed [DATA_W-1:0] result
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_x;
    logic signed [ACC_W-1:0]    acc;
    logic signed [CALC_W-1:0]   acc_x;
    logic signed [CALC_W-1:0]   bias_x;
    logic signed [DATA_W-1:0]   sat_q;

    assign prod   = a * b;
    assign prod_x = $signed({{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc + prod_x;
    end

    assign acc_x  = $signed({{(CALC_W-ACC_W){acc[ACC_W-1]}}, acc});
    assign bias_x = $signed({{(CALC_W-DATA_W){bias[DATA_W-1]}}, bias});
    assign sat_q  = DATA_W'(round_sat(acc_x + (bias_x <<< FRAC_W), FRAC_W, DATA_W));

`ifdef NEURON_RELU_EN
    assign result = sat_q[DATA_W-1] ? '0 : sat_q;
`else
    assign result = sat_q;
`endif

endmodule

// File: rtl/neuron_layer_seq.sv
// neuron_layer_seq
// Fully-connected layer, N_IN signed activations in, N_OUT out, computed
// one product per cycle on a single shared MAC. Weights and biases live in a
// small register file written through the cfg port while the layer is idle.
// Macro: NEURON_RELU_EN (see neuron_mac) selects ReLU on the outputs.
// Ports:
//   clk, rst_n                  clock / async active-low reset
//   in_valid, in_ready, in_data input vector handshake, element i at [i*DATA_W +: DATA_W]
//   out_valid, out_ready, out_data result vector handshake, neuron o at [o*DATA_W +: DATA_W]
//   cfg_we, cfg_addr, cfg_wdata  register write: addr o*N_IN+i -> weight, N_OUT*N_IN+o -> bias
//   cfg_ready                   high only when idle; writes while busy are dropped
//
// state | meaning
// IDLE  | waiting for an input vector, cfg writes accepted
// MAC   | accumulating in[i]*w[o*N_IN+i] for neuron o, one i per cycle
// BIAS  | add bias, round, saturate, store out slot o, clear accumulator
// DONE  | result vector presented until out_ready
module neuron_layer_seq
    import neuron_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int N_IN   = 2,
    parameter int N_OUT  = 9
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [N_IN*DATA_W-1:0]            in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [N_OUT*DATA_W-1:0]           out_data,
    input  logic                              cfg_we,
    input  logic [$clog2(N_OUT*(N_IN+1))-1:0] cfg_addr,
    input  logic [DATA_W-1:0]                 cfg_wdata,
    output logic                              cfg_ready
);

    localparam int ACC_W  = 2*DATA_W + $clog2(N_IN) + 1;
    localparam int N_CFG  = N_OUT*(N_IN+1);
    localparam int CFG_AW = $clog2(N_CFG);
    localparam int IW     = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int OW     = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] MAC  = ST_MAC;
    localparam logic [1:0] BIAS = ST_BIAS;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]              state;
    logic [IW-1:0]           i_idx;
    logic [OW-1:0]           o_idx;
    logic [N_IN*DATA_W-1:0]  in_reg;
    logic [N_OUT*DATA_W-1:0] out_reg;
    logic [DATA_W-1:0]       cfg_mem [N_CFG];
    logic [CFG_AW-1:0]       w_addr;
    logic [CFG_AW-1:0]       b_addr;
    logic signed [DATA_W-1:0] mac_result;

    assign in_ready  = (state == IDLE);
    assign cfg_ready = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = out_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CFG; k++)
                cfg_mem[k] <= '0;
        end else if (cfg_we && (state == IDLE) && (32'(cfg_addr) < N_CFG)) begin
            cfg_mem[cfg_addr] <= cfg_wdata;
        end
    end

    assign w_addr = CFG_AW'(o_idx) * CFG_AW'(N_IN) + CFG_AW'(i_idx);
    assign b_addr = CFG_AW'(N_OUT*N_IN) + CFG_AW'(o_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            i_idx   <= '0;
            o_idx   <= '0;
            in_reg  <= '0;
            out_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_reg <= in_data;
                        i_idx  <= '0;
                        o_idx  <= '0;
                        state  <= MAC;
                    end
                end
                MAC: begin
                    if (i_idx == IW'(N_IN-1)) begin
                        i_idx <= '0;
                        state <= BIAS;
                    end else begin
                        i_idx <= i_idx + 1'b1;
                    end
                end
                BIAS: begin
                    out_reg[o_idx*DATA_W +: DATA_W] <= mac_result;
                    if (o_idx == OW'(N_OUT-1)) begin
                        state <= DONE;
                    end else begin
                        o_idx <= o_idx + 1'b1;
                        state <= MAC;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Accumulator is cleared while idle and in every BIAS cycle, so each
    // neuron starts its MAC run from zero.
    neuron_mac #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    ((state == IDLE) || (state == BIAS)),
        .en     (state == MAC),
        .a      ($signed(in_reg[i_idx*DATA_W +: DATA_W])),
        .b      ($signed(cfg_mem[w_addr])),
        .bias   ($signed(cfg_mem[b_addr])),
        .result (mac_result)
    );

endmodule

// File: tb/tb_neuron_layer_seq.sv
// tb_neuron_layer_seq
// Self-checking bench for neuron_layer_seq at default parameters (Q8.12,
// 2 inputs, 9 neurons). Expected outputs come from an arithmetic model of the
// layer kept in plain longint arrays.
module tb_neuron_layer_seq;

    localparam int DATA_W = 20;
    localparam int FRAC_W = 12;
    localparam int N_IN   = 2;
    localparam int N_OUT  = 9;
    localparam int N_W    = N_OUT*N_IN;
    localparam int N_CFG  = N_OUT*(N_IN+1);
    localparam int CFG_AW = 5;
    localparam int LAT    = N_OUT*(N_IN+1) + 1;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic [N_IN*DATA_W-1:0]    in_data = '0;
    logic                      out_valid;
    logic                      out_ready = 1'b0;
    logic [N_OUT*DATA_W-1:0]   out_data;
    logic                      cfg_we = 1'b0;
    logic [CFG_AW-1:0]         cfg_addr = '0;
    logic [DATA_W-1:0]         cfg_wdata = '0;
    logic                      cfg_ready;

    int checks = 0;
    int errors = 0;

    longint wm [N_W];
    longint bm [N_OUT];

    always #5 clk = ~clk;

    neuron_layer_seq #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .N_IN   (N_IN),
        .N_OUT  (N_OUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_ready (cfg_ready)
    );

    function automatic longint sx(input logic [DATA_W-1:0] v);
        longint r;
        r = $signed(v);
        return r;
    endfunction

    // Layer output for neuron o: sum of products plus scaled bias, rounded
    // half up, clamped to the 20-bit signed range.
    function automatic logic [DATA_W-1:0] model_out(input logic [N_IN*DATA_W-1:0] vec, input int o);
        longint s;
        longint r;
        longint one;
        longint hi;
        longint lo;
        one = longint'(1) << FRAC_W;
        hi  = (longint'(1) << (DATA_W-1)) - 1;
        lo  = -(longint'(1) << (DATA_W-1));
        s   = 0;
        for (int i = 0; i < N_IN; i++)
            s += sx(vec[i*DATA_W +: DATA_W]) * wm[o*N_IN+i];
        s += bm[o] * one + one / 2;
        r = s >>> FRAC_W;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
`ifdef NEURON_RELU_EN
        if (r < 0) r = 0;
`endif
        return DATA_W'(r);
    endfunction

    task automatic clear_model();
        for (int k = 0; k < N_W; k++) wm[k] = 0;
        for (int k = 0; k < N_OUT; k++) bm[k] = 0;
    endtask

    // Called at #1 after a rising edge; returns at #1 after a rising edge.
    task automatic cfg_write(input int addr, input logic [DATA_W-1:0] d, input bit taken);
        cfg_we    = 1'b1;
        cfg_addr  = CFG_AW'(addr);
        cfg_wdata = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        if (taken && addr < N_CFG) begin
            if (addr < N_W) wm[addr] = sx(d);
            else            bm[addr-N_W] = sx(d);
        end
    endtask

    task automatic set_weights(input logic [DATA_W-1:0] even_w, input logic [DATA_W-1:0] odd_w);
        for (int k = 0; k < N_W; k++)
            cfg_write(k, (k % 2 == 0) ? even_w : odd_w, 1'b1);
    endtask

    // Sends one vector, checks latency, result, hold behaviour and handshake.
    // busy_addr >= 0 issues a cfg write mid-compute that must be dropped.
    task automatic run_vector(input string name, input logic [N_IN*DATA_W-1:0] vec,
                              input int hold, input int busy_addr,
                              output logic [N_OUT*DATA_W-1:0] got);
        logic [N_OUT*DATA_W-1:0] exp_v;
        int cyc;
        for (int o = 0; o < N_OUT; o++)
            exp_v[o*DATA_W +: DATA_W] = model_out(vec, o);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready_idle got %b exp 1", name, in_ready);
        end
        in_valid = 1'b1;
        in_data  = vec;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 200) begin
            if (cyc == 5 && busy_addr >= 0) begin
                checks++;
                if (cfg_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s cfg_ready_busy got %b exp 0", name, cfg_ready);
                end
                cfg_we    = 1'b1;
                cfg_addr  = CFG_AW'(busy_addr);
                cfg_wdata = DATA_W'($urandom);
            end else begin
                cfg_we = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        cfg_we = 1'b0;
        checks++;
        if (cyc !== LAT) begin
            errors++;
            $display("FAIL %s latency got %0d exp %0d", name, cyc, LAT);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s in_ready_done got %b exp 0", name, in_ready);
        end
        checks++;
        if (out_data !== exp_v) begin
            errors++;
            $display("FAIL %s out_data got %h exp %h", name, out_data, exp_v);
        end
        got = out_data;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_v || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d got v=%b rdy=%b d=%h exp v=1 rdy=0 d=%h",
                         name, h, out_valid, in_ready, out_data, exp_v);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s after_handshake got v=%b rdy=%b exp v=0 rdy=1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || cfg_ready !== 1'b1 || out_data !== '0) begin
            errors++;
            $display("FAIL reset got in_ready=%b out_valid=%b cfg_ready=%b out_data=%h exp 1 0 1 0",
                     in_ready, out_valid, cfg_ready, out_data);
        end
    endtask

    task automatic test_directed();
        logic [N_OUT*DATA_W-1:0] got;
        logic [DATA_W-1:0] e;
        set_weights(20'h01000, 20'h01000);
        run_vector("unit_weights", {20'hFED26, 20'h05AF4}, 0, -1, got);
        checks++;
        if (got[4*DATA_W +: DATA_W] !== 20'h0481A) begin
            errors++;
            $display("FAIL unit_weights_const got %h exp 0481a", got[4*DATA_W +: DATA_W]);
        end
        set_weights(20'h7FFFF, 20'h7FFFF);
        run_vector("sat_pos", {20'h7FFFF, 20'h7FFFF}, 0, -1, got);
        checks++;
        if (got[0 +: DATA_W] !== 20'h7FFFF) begin
            errors++;
            $display("FAIL sat_pos_const got %h exp 7ffff", got[0 +: DATA_W]);
        end
        run_vector("sat_neg", {20'h80001, 20'h80001}, 0, -1, got);
`ifdef NEURON_RELU_EN
        e = 20'h00000;
`else
        e = 20'h80000;
`endif
        checks++;
        if (got[8*DATA_W +: DATA_W] !== e) begin
            errors++;
            $display("FAIL sat_neg_const got %h exp %h", got[8*DATA_W +: DATA_W], e);
        end
        set_weights(20'h00800, 20'h00000);
        run_vector("round_up", {DATA_W'($urandom), 20'h00001}, 0, -1, got);
        checks++;
        if (got[0 +: DATA_W] !== 20'h00001) begin
            errors++;
            $display("FAIL round_up_const got %h exp 00001", got[0 +: DATA_W]);
        end
        run_vector("round_neg", {DATA_W'($urandom), 20'hFFFFF}, 0, -1, got);
        checks++;
        if (got[0 +: DATA_W] !== 20'h00000) begin
            errors++;
            $display("FAIL round_neg_const got %h exp 00000", got[0 +: DATA_W]);
        end
    endtask

    task automatic test_bias_busy_cfg();
        logic [N_OUT*DATA_W-1:0] got;
        set_weights(20'h00000, 20'h00000);
        for (int o = 0; o < N_OUT; o++)
            cfg_write(N_W + o, DATA_W'(o * 32'h1000), 1'b1);
        run_vector("bias_busy_wr", {DATA_W'($urandom), DATA_W'($urandom)}, 0, N_W + 3, got);
        checks++;
        if (got[7*DATA_W +: DATA_W] !== 20'h07000) begin
            errors++;
            $display("FAIL bias_const got %h exp 07000", got[7*DATA_W +: DATA_W]);
        end
        run_vector("bias_after_drop", {DATA_W'($urandom), DATA_W'($urandom)}, 0, -1, got);
    endtask

    task automatic test_backpressure();
        logic [N_OUT*DATA_W-1:0] got;
        set_weights(20'h01800, 20'hFF400);
        run_vector("backpressure", {DATA_W'($urandom_range(0, 32'hFFFF)), DATA_W'($urandom_range(0, 32'hFFFF))}, 5, -1, got);
        run_vector("after_backpressure", {DATA_W'($urandom), DATA_W'($urandom)}, 0, -1, got);
    endtask

    task automatic test_cfg_range();
        logic [N_OUT*DATA_W-1:0] got;
        for (int a = N_CFG; a < 32; a++)
            cfg_write(a, DATA_W'($urandom), 1'b1);
        run_vector("cfg_out_of_range", {DATA_W'($urandom), DATA_W'($urandom)}, 0, -1, got);
    endtask

    task automatic test_random();
        logic [N_OUT*DATA_W-1:0] got;
        logic [DATA_W-1:0] d;
        int v;
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < N_CFG; a++) begin
                if (it % 2 == 0) begin
                    d = DATA_W'($urandom);
                end else begin
                    v = int'($urandom_range(0, 16383)) - 8192;
                    d = v[DATA_W-1:0];
                end
                cfg_write(a, d, 1'b1);
            end
            run_vector($sformatf("random%0d", it), {DATA_W'($urandom), DATA_W'($urandom)},
                       int'($urandom_range(0, 3)), -1, got);
        end
    endtask

    task automatic test_reset_abort();
        logic [N_OUT*DATA_W-1:0] got;
        bit seen;
        set_weights(20'h01000, 20'h02000);
        for (int o = 0; o < N_OUT; o++)
            cfg_write(N_W + o, 20'h00100, 1'b1);
        in_valid = 1'b1;
        in_data  = {20'h01000, 20'h01000};
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        clear_model();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || cfg_ready !== 1'b1 || out_data !== '0) begin
            errors++;
            $display("FAIL abort_reset got v=%b rdy=%b cfg=%b d=%h exp 0 1 1 0",
                     out_valid, in_ready, cfg_ready, out_data);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 35; c++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_valid got out_valid seen=%b exp 0", seen);
        end
        run_vector("post_abort_zero", {DATA_W'($urandom), DATA_W'($urandom)}, 0, -1, got);
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL post_abort_const got %h exp 0", got);
        end
    endtask

    initial begin
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_bias_busy_cfg();
        test_backpressure();
        test_cfg_range();
        test_random();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
